// File: rtl/rv_core_pkg.sv
// Shared scalar-core types: ALU op encoding, default widths and the ID/EX record.
// Also provides the register-hit test used by operand forwarding.
package rv_core_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001,
        ALU_BEQ  = 4'b1010,
        ALU_BNE  = 4'b1011,
        ALU_BLT  = 4'b1100,
        ALU_BGE  = 4'b1101,
        ALU_BLTU = 4'b1110,
        ALU_BGEU = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic [REG_ADDR_W_DEF-1:0] rs1_addr;
        logic [REG_ADDR_W_DEF-1:0] rs2_addr;
        logic [REG_ADDR_W_DEF-1:0] rd_addr;
        logic [DATA_WIDTH_DEF-1:0] rs1_data;
        logic [DATA_WIDTH_DEF-1:0] rs2_data;
        logic [DATA_WIDTH_DEF-1:0] imm;
        logic                      use_imm;
        alu_op_e                   alu_op;
        logic                      rd_we;
    } id_ex_t;

    // x0 is hard-wired to zero, so a write to it never counts as a hit.
    function automatic logic reg_hit(input logic                      we,
                                     input logic [REG_ADDR_W_DEF-1:0] rd,
                                     input logic [REG_ADDR_W_DEF-1:0] src);
        return we && (rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: x0 -> zero, then MEM result, then WB result, then the stored value.
// A MEM result still waiting on load data is not forwarded.
module operand_fwd_mux
    import rv_core_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] src_addr_i,
    input  logic [DATA_WIDTH-1:0] stored_data_i,
    input  logic                  mem_we_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_load_pend_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = reg_hit(mem_we_i, mem_rd_i, src_addr_i) && !mem_load_pend_i;
    assign wb_hit  = reg_hit(wb_we_i, wb_rd_i, src_addr_i);

    always_comb begin
        data_o = stored_data_i;
        if (src_addr_i == '0) begin
            data_o = '0;
        end else if (mem_hit) begin
            data_o = mem_data_i;
        end else if (wb_hit) begin
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the scalar ALU: holds one decoded instruction, forwards
// MEM/WB results into its operands and stalls on load-use hazards.
module ex_operand_stage
    import rv_core_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  dec_valid_i,
    output logic                  dec_ready_o,
    input  logic [REG_ADDR_W-1:0] dec_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] dec_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] dec_rs2_data_i,
    input  logic [DATA_WIDTH-1:0] dec_imm_i,
    input  logic                  dec_use_imm_i,
    input  logic [3:0]            dec_alu_op_i,
    input  logic                  dec_rd_we_i,
    input  logic                  mem_we_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_load_pend_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
    output logic [3:0]            ex_alu_op_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic                  ex_rd_we_o,
    output logic                  hazard_stall_o
);

    // The stored record uses the package widths; the parameters are expected to match them.
    id_ex_t ex_q, ex_d;
    logic   occ_q, occ_d;

    logic                  hazard;
    logic                  consume;
    logic                  capture;
    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;

    assign hazard = occ_q && mem_we_i && mem_load_pend_i && (mem_rd_i != '0) &&
                    ((mem_rd_i == ex_q.rs1_addr) ||
                     (!ex_q.use_imm && (mem_rd_i == ex_q.rs2_addr)));

    assign ex_valid_o     = occ_q && !hazard && !flush_i;
    assign hazard_stall_o = hazard;
    assign consume        = ex_valid_o && ex_ready_i;
    assign dec_ready_o    = !occ_q || consume;
    assign capture        = dec_valid_i && dec_ready_o && !flush_i;

    operand_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .src_addr_i      (ex_q.rs1_addr),
        .stored_data_i   (ex_q.rs1_data),
        .mem_we_i        (mem_we_i),
        .mem_rd_i        (mem_rd_i),
        .mem_data_i      (mem_data_i),
        .mem_load_pend_i (mem_load_pend_i),
        .wb_we_i         (wb_we_i),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .data_o          (rs1_fwd)
    );

    operand_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .src_addr_i      (ex_q.rs2_addr),
        .stored_data_i   (ex_q.rs2_data),
        .mem_we_i        (mem_we_i),
        .mem_rd_i        (mem_rd_i),
        .mem_data_i      (mem_data_i),
        .mem_load_pend_i (mem_load_pend_i),
        .wb_we_i         (wb_we_i),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .data_o          (rs2_fwd)
    );

    assign ex_rs1_data_o = rs1_fwd;
    assign ex_rs2_data_o = ex_q.use_imm ? ex_q.imm : rs2_fwd;
    assign ex_alu_op_o   = ex_q.alu_op;
    assign ex_rd_addr_o  = ex_q.rd_addr;
    assign ex_rd_we_o    = ex_q.rd_we;

    always_comb begin
        occ_d = occ_q;
        ex_d  = ex_q;
        if (capture) begin
            // The regfile does not write through, so a same-cycle WB write is picked up here.
            occ_d         = 1'b1;
            ex_d.rs1_addr = dec_rs1_addr_i;
            ex_d.rs2_addr = dec_rs2_addr_i;
            ex_d.rd_addr  = dec_rd_addr_i;
            ex_d.rs1_data = reg_hit(wb_we_i, wb_rd_i, dec_rs1_addr_i) ? wb_data_i : dec_rs1_data_i;
            ex_d.rs2_data = reg_hit(wb_we_i, wb_rd_i, dec_rs2_addr_i) ? wb_data_i : dec_rs2_data_i;
            ex_d.imm      = dec_imm_i;
            ex_d.use_imm  = dec_use_imm_i;
            ex_d.alu_op   = alu_op_e'(dec_alu_op_i);
            ex_d.rd_we    = dec_rd_we_i;
        end else if (consume) begin
            occ_d = 1'b0;
        end else if (occ_q) begin
            // A stalled instruction absorbs WB writes so the value survives once WB moves on.
            if (reg_hit(wb_we_i, wb_rd_i, ex_q.rs1_addr)) ex_d.rs1_data = wb_data_i;
            if (reg_hit(wb_we_i, wb_rd_i, ex_q.rs2_addr)) ex_d.rs2_data = wb_data_i;
        end
        if (flush_i) begin
            occ_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= 1'b0;
            ex_q  <= '0;
        end else begin
            occ_q <= occ_d;
            ex_q  <= ex_d;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: stimulus pushes expected ALU issues into a
// scoreboard queue, a monitor pops and compares on every ex_valid_o & ex_ready_i.
module tb_ex_operand_stage;
    import rv_core_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          dec_valid_i;
    logic          dec_ready_o;
    logic [AW-1:0] dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i;
    logic [DW-1:0] dec_rs1_data_i, dec_rs2_data_i, dec_imm_i;
    logic          dec_use_imm_i;
    logic [3:0]    dec_alu_op_i;
    logic          dec_rd_we_i;
    logic          mem_we_i;
    logic [AW-1:0] mem_rd_i;
    logic [DW-1:0] mem_data_i;
    logic          mem_load_pend_i;
    logic          wb_we_i;
    logic [AW-1:0] wb_rd_i;
    logic [DW-1:0] wb_data_i;
    logic          ex_valid_o;
    logic          ex_ready_i;
    logic [DW-1:0] ex_rs1_data_o, ex_rs2_data_o;
    logic [3:0]    ex_alu_op_o;
    logic [AW-1:0] ex_rd_addr_o;
    logic          ex_rd_we_o;
    logic          hazard_stall_o;

    typedef struct {
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic          rd_we;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_operand_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .dec_valid_i     (dec_valid_i),
        .dec_ready_o     (dec_ready_o),
        .dec_rs1_addr_i  (dec_rs1_addr_i),
        .dec_rs2_addr_i  (dec_rs2_addr_i),
        .dec_rd_addr_i   (dec_rd_addr_i),
        .dec_rs1_data_i  (dec_rs1_data_i),
        .dec_rs2_data_i  (dec_rs2_data_i),
        .dec_imm_i       (dec_imm_i),
        .dec_use_imm_i   (dec_use_imm_i),
        .dec_alu_op_i    (dec_alu_op_i),
        .dec_rd_we_i     (dec_rd_we_i),
        .mem_we_i        (mem_we_i),
        .mem_rd_i        (mem_rd_i),
        .mem_data_i      (mem_data_i),
        .mem_load_pend_i (mem_load_pend_i),
        .wb_we_i         (wb_we_i),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .ex_valid_o      (ex_valid_o),
        .ex_ready_i      (ex_ready_i),
        .ex_rs1_data_o   (ex_rs1_data_o),
        .ex_rs2_data_o   (ex_rs2_data_o),
        .ex_alu_op_o     (ex_alu_op_o),
        .ex_rd_addr_o    (ex_rd_addr_o),
        .ex_rd_we_o      (ex_rd_we_o),
        .hazard_stall_o  (hazard_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rs1a, input logic [DW-1:0] rs1d,
                         input logic [AW-1:0] rs2a, input logic [DW-1:0] rs2d,
                         input logic [AW-1:0] rd,   input logic [DW-1:0] imm,
                         input logic use_imm, input logic [3:0] op);
        dec_valid_i    = 1'b1;
        dec_rs1_addr_i = rs1a;
        dec_rs1_data_i = rs1d;
        dec_rs2_addr_i = rs2a;
        dec_rs2_data_i = rs2d;
        dec_rd_addr_i  = rd;
        dec_imm_i      = imm;
        dec_use_imm_i  = use_imm;
        dec_alu_op_i   = op;
        dec_rd_we_i    = 1'b1;
    endtask

    task automatic push(input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                        input logic [3:0] op, input logic [AW-1:0] rd);
        exp_t e;
        e.rs1 = rs1; e.rs2 = rs2; e.op = op; e.rd = rd; e.rd_we = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic clear_fwd();
        mem_we_i = 1'b0; mem_rd_i = '0; mem_data_i = '0; mem_load_pend_i = 1'b0;
        wb_we_i  = 1'b0; wb_rd_i  = '0; wb_data_i  = '0;
    endtask

    // Monitor: every accepted issue must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && ex_valid_o && ex_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got op=%h rd=%0d expected no issue", ex_alu_op_o, ex_rd_addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn op=%h rd=%0d rs1=%h rs2=%h", ex_alu_op_o, ex_rd_addr_o, ex_rs1_data_o, ex_rs2_data_o);
                chk("txn_rs1",   ex_rs1_data_o, mon_e.rs1);
                chk("txn_rs2",   ex_rs2_data_o, mon_e.rs2);
                chk("txn_op",    {28'd0, ex_alu_op_o}, {28'd0, mon_e.op});
                chk("txn_rd",    {27'd0, ex_rd_addr_o}, {27'd0, mon_e.rd});
                chk("txn_rd_we", {31'd0, ex_rd_we_o}, {31'd0, mon_e.rd_we});
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
        dec_valid_i = 1'b0; dec_rs1_addr_i = '0; dec_rs2_addr_i = '0; dec_rd_addr_i = '0;
        dec_rs1_data_i = '0; dec_rs2_data_i = '0; dec_imm_i = '0; dec_use_imm_i = 1'b0;
        dec_alu_op_i = '0; dec_rd_we_i = 1'b0;
        clear_fwd();

        // Reset state
        @(negedge clk);
        chk("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("rst_hazard",   {31'd0, hazard_stall_o}, 32'd0);
        chk("rst_dec_ready",{31'd0, dec_ready_o}, 32'd1);
        chk("rst_rs1",      ex_rs1_data_o, 32'd0);
        chk("rst_rs2",      ex_rs2_data_o, 32'd0);
        chk("rst_op",       {28'd0, ex_alu_op_o}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Back-to-back ADD then SUB with no forwarding
        ex_ready_i = 1'b1;
        issue(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 1'b0, 4'b0000);
        push(32'd5, 32'd7, 4'b0000, 5'd3);
        @(negedge clk);
        chk("b2b_ready_idle", {31'd0, dec_ready_o}, 32'd1);
        chk("b2b_valid_idle", {31'd0, ex_valid_o}, 32'd0);
        tick();
        issue(5'd5, 32'd10, 5'd6, 32'd3, 5'd7, 32'd0, 1'b0, 4'b0001);
        push(32'd10, 32'd3, 4'b0001, 5'd7);
        @(negedge clk);
        chk("b2b_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("b2b_ready_full", {31'd0, dec_ready_o}, 32'd1);
        tick();
        dec_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_valid2", {31'd0, ex_valid_o}, 32'd1);
        tick();

        // MEM result beats WB result for the same register
        ex_ready_i = 1'b0;
        issue(5'd3, 32'd1, 5'd0, 32'd0, 5'd8, 32'h10, 1'b1, 4'b0101);
        tick();
        dec_valid_i = 1'b0;
        mem_we_i = 1'b1; mem_rd_i = 5'd3; mem_data_i = 32'hAA;
        wb_we_i  = 1'b1; wb_rd_i  = 5'd3; wb_data_i  = 32'hBB;
        @(negedge clk);
        chk("fwd_mem_wins", ex_rs1_data_o, 32'hAA);
        chk("fwd_imm_b",    ex_rs2_data_o, 32'h10);
        chk("fwd_ready_held", {31'd0, dec_ready_o}, 32'd0);
        tick();
        ex_ready_i = 1'b1;
        push(32'hAA, 32'h10, 4'b0101, 5'd8);
        tick();
        clear_fwd();

        // Load-use on rs2: stall two cycles, then the load arrives at WB
        issue(5'd1, 32'd2, 5'd4, 32'd9, 5'd9, 32'd0, 1'b0, 4'b1000);
        tick();
        dec_valid_i = 1'b0;
        mem_we_i = 1'b1; mem_rd_i = 5'd4; mem_load_pend_i = 1'b1; mem_data_i = 32'hDEAD;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("lu_hazard", {31'd0, hazard_stall_o}, 32'd1);
            chk("lu_valid",  {31'd0, ex_valid_o}, 32'd0);
            chk("lu_ready",  {31'd0, dec_ready_o}, 32'd0);
            tick();
        end
        clear_fwd();
        wb_we_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 32'h1234;
        push(32'd2, 32'h1234, 4'b1000, 5'd9);
        @(negedge clk);
        chk("lu_release_hazard", {31'd0, hazard_stall_o}, 32'd0);
        chk("lu_release_valid",  {31'd0, ex_valid_o}, 32'd1);
        tick();
        clear_fwd();

        // Same load with operand B from the immediate: no stall
        issue(5'd1, 32'd2, 5'd4, 32'd9, 5'd10, 32'h33, 1'b1, 4'b1001);
        tick();
        dec_valid_i = 1'b0;
        mem_we_i = 1'b1; mem_rd_i = 5'd4; mem_load_pend_i = 1'b1;
        push(32'd2, 32'h33, 4'b1001, 5'd10);
        @(negedge clk);
        chk("imm_no_hazard", {31'd0, hazard_stall_o}, 32'd0);
        chk("imm_valid",     {31'd0, ex_valid_o}, 32'd1);
        tick();
        clear_fwd();

        // x0 source is never forwarded
        issue(5'd0, 32'h77, 5'd2, 32'd4, 5'd11, 32'd0, 1'b0, 4'b0011);
        tick();
        dec_valid_i = 1'b0;
        mem_we_i = 1'b1; mem_rd_i = 5'd0; mem_data_i = 32'hFFFF;
        wb_we_i  = 1'b1; wb_rd_i  = 5'd0; wb_data_i  = 32'hEEEE;
        push(32'd0, 32'd4, 4'b0011, 5'd11);
        @(negedge clk);
        chk("x0_zero", ex_rs1_data_o, 32'd0);
        tick();
        clear_fwd();

        // Stall refresh: WB writes rs1 while EX is not ready
        ex_ready_i = 1'b0;
        issue(5'd6, 32'd1, 5'd7, 32'd2, 5'd12, 32'd0, 1'b0, 4'b0111);
        tick();
        dec_valid_i = 1'b0;
        wb_we_i = 1'b1; wb_rd_i = 5'd6; wb_data_i = 32'h55;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("refresh_rs1",   ex_rs1_data_o, 32'h55);
            chk("refresh_ready", {31'd0, dec_ready_o}, 32'd0);
            chk("refresh_op",    {28'd0, ex_alu_op_o}, 32'd7);
            tick();
            clear_fwd();
        end
        ex_ready_i = 1'b1;
        push(32'h55, 32'd2, 4'b0111, 5'd12);
        tick();

        // Flush kills the held instruction and the one offered alongside it
        ex_ready_i = 1'b0;
        issue(5'd1, 32'd3, 5'd2, 32'd4, 5'd13, 32'd0, 1'b0, 4'b0000);
        tick();
        issue(5'd1, 32'h99, 5'd2, 32'd4, 5'd14, 32'd0, 1'b0, 4'b0001);
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_valid_now", {31'd0, ex_valid_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        dec_valid_i = 1'b0;
        ex_ready_i = 1'b1;
        @(negedge clk);
        chk("flush_valid_next", {31'd0, ex_valid_o}, 32'd0);
        chk("flush_ready_next", {31'd0, dec_ready_o}, 32'd1);
        tick();

        // Asynchronous reset during a load-use stall
        issue(5'd5, 32'd1, 5'd0, 32'd0, 5'd15, 32'd0, 1'b0, 4'b0000);
        tick();
        dec_valid_i = 1'b0;
        mem_we_i = 1'b1; mem_rd_i = 5'd5; mem_load_pend_i = 1'b1;
        @(negedge clk);
        chk("rstmid_hazard_before", {31'd0, hazard_stall_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_valid",  {31'd0, ex_valid_o}, 32'd0);
        chk("rstmid_hazard", {31'd0, hazard_stall_o}, 32'd0);
        chk("rstmid_ready",  {31'd0, dec_ready_o}, 32'd1);
        tick();
        clear_fwd();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, ex_valid_o}, 32'd0);
        tick();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
